leiwand_rv32_wb_interconnect: RTL and testbench

//  Single-master, N-slave Wishbone (pipelined) address decoder and response mux between core and memories/peripherals.

---
 rtl/leiwand_rv32_wb_interconnect.sv | 137 +++++++++++++
 tb/tb_leiwand_rv32_wb_interconnect.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone decoder and response mux.
// Tracks one outstanding transfer and flags unmapped or timed-out accesses.
module leiwand_rv32_wb_interconnect #(
  parameter int unsigned MEM_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = {32'h20400000, 32'h10000000},
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE = {32'h00001000, 32'h00001000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            m_cyc,
  input  logic                            m_stb,
  input  logic                            m_we,
  input  logic [MEM_WIDTH-1:0]            m_addr,
  input  logic [MEM_WIDTH-1:0]            m_data_out,
  output logic [MEM_WIDTH-1:0]            m_data_in,
  output logic                            m_ack,
  output logic                            m_err,
  output logic                            m_stall,
  output logic [NUM_SLAVES-1:0]           s_stb,
  input  logic [NUM_SLAVES-1:0]           s_ack,
  input  logic [NUM_SLAVES-1:0]           s_stall,
  input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_data_in,
  output logic [MEM_WIDTH-1:0]            err_addr,
  output logic                            err_valid
);

  localparam int unsigned SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t               state;
  logic [SEL_W-1:0]     sel;
  logic [7:0]           cnt;
  logic [MEM_WIDTH-1:0] addr_q;

  logic                 req;
  logic                 hit;
  logic [SEL_W-1:0]     hit_idx;

  // Write-side signals fan out to the slaves outside this block.
  logic unused_fanout;
  assign unused_fanout = ^{m_we, m_data_out};

  assign req = m_cyc & m_stb;

  // Window decode; descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = int'(NUM_SLAVES) - 1; k >= 0; k--) begin
      if (SLAVE_SIZE[k*MEM_WIDTH +: MEM_WIDTH] != '0 &&
          m_addr >= SLAVE_BASE[k*MEM_WIDTH +: MEM_WIDTH] &&
          (m_addr - SLAVE_BASE[k*MEM_WIDTH +: MEM_WIDTH]) < SLAVE_SIZE[k*MEM_WIDTH +: MEM_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // Strobe, stall and the zero-latency ack/data path from the selected slave.
  always_comb begin
    s_stb     = '0;
    m_stall   = 1'b0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_data_in = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            s_stb[hit_idx] = 1'b1;
            m_stall        = s_stall[hit_idx];
          end
        end
        ACTIVE: begin
          m_stall = 1'b1;
          if (m_cyc && s_ack[sel]) begin
            m_ack     = 1'b1;
            m_data_in = s_data_in[sel*MEM_WIDTH +: MEM_WIDTH];
          end
        end
        ERROR: begin
          m_stall = 1'b1;
          m_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      addr_q    <= '0;
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (!hit) begin
              addr_q <= m_addr;
              state  <= ERROR;
            end else if (!s_stall[hit_idx]) begin
              sel    <= hit_idx;
              addr_q <= m_addr;
              cnt    <= '0;
              state  <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          // Abort beats ack, ack beats timeout.
          if (!m_cyc || s_ack[sel]) begin
            state <= IDLE;
          end else if (cnt == TO_LAST) begin
            state <= ERROR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERROR: begin
          err_addr  <= addr_q;
          err_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// Directed bench for the Wishbone interconnect; responses checked by a
// queue-based scoreboard, static outputs checked inline.
module tb_leiwand_rv32_wb_interconnect;

  localparam int unsigned W = 32;
  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           m_cyc, m_stb, m_we;
  logic [W-1:0]   m_addr, m_data_out, m_data_in;
  logic           m_ack, m_err, m_stall;
  logic [N-1:0]   s_stb, s_ack, s_stall;
  logic [N*W-1:0] s_data_in;
  logic [W-1:0]   err_addr;
  logic           err_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Expected responses: bit W set = error, low bits = read data.
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;

  always #5 clk = ~clk;

  leiwand_rv32_wb_interconnect #(
    .MEM_WIDTH      (W),
    .NUM_SLAVES     (N),
    .SLAVE_BASE     ({32'h20400000, 32'h10000000}),
    .SLAVE_SIZE     ({32'h00001000, 32'h00001000}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_cyc      (m_cyc),
    .m_stb      (m_stb),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .m_stall    (m_stall),
    .s_stb      (s_stb),
    .s_ack      (s_ack),
    .s_stall    (s_stall),
    .s_data_in  (s_data_in),
    .err_addr   (err_addr),
    .err_valid  (err_valid)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    m_cyc     = 1'b0;
    m_stb     = 1'b0;
    s_ack     = '0;
    s_stall   = '0;
    s_data_in = '0;
  endtask

  // Response monitor: every ack/err must match the next queued expectation.
  always @(negedge clk) begin
    if (m_ack || m_err) begin
      check("ack_err_exclusive", W'(m_ack & m_err), '0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_response: got ack=%b err=%b data=%h expected none",
                 m_ack, m_err, m_data_in);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_kind", W'(m_err), W'(mon_e[W]));
        check("resp_data", m_data_in, mon_e[W-1:0]);
      end
    end
  end

  initial begin
    int first;
    reset      = 1'b0;
    m_we       = 1'b0;
    m_data_out = '0;
    m_addr     = '0;
    idle_bus();
    tick();
    tick();
    settle();
    check("rst_m_ack", W'(m_ack), '0);
    check("rst_m_err", W'(m_err), '0);
    check("rst_m_stall", W'(m_stall), '0);
    check("rst_s_stb", W'(s_stb), '0);
    check("rst_m_data_in", m_data_in, '0);
    check("rst_err_addr", err_addr, '0);
    check("rst_err_valid", W'(err_valid), '0);
    tick();
    reset = 1'b1;
    tick();

    // Slave 0 read, ack in second active cycle.
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h10000004;
    settle();
    check("t1_s_stb", W'(s_stb), 32'h1);
    check("t1_stall", W'(m_stall), '0);
    tick();
    m_stb = 1'b0;
    settle();
    check("t1_s_stb_active", W'(s_stb), '0);
    check("t1_stall_active", W'(m_stall), 32'h1);
    tick();
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    s_ack = 2'b01; s_data_in[31:0] = 32'hDEADBEEF;
    settle();
    tick();
    idle_bus();

    // Slave 1 stalls three cycles before accepting.
    tick();
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h20400000; s_stall = 2'b10;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t2_stall_held", W'(m_stall), 32'h1);
      check("t2_s_stb_held", W'(s_stb), 32'h2);
      tick();
    end
    s_stall = '0;
    settle();
    check("t2_stall_accept", W'(m_stall), '0);
    check("t2_s_stb_accept", W'(s_stb), 32'h2);
    tick();
    m_stb = 1'b0;
    exp_q.push_back({1'b0, 32'h12345678});
    s_ack = 2'b10; s_data_in[63:32] = 32'h12345678;
    settle();
    tick();
    idle_bus();

    // Unmapped address.
    tick();
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h30000000;
    exp_q.push_back({1'b1, 32'h0});
    settle();
    check("t3_no_s_stb", W'(s_stb), '0);
    check("t3_stall", W'(m_stall), '0);
    tick();
    idle_bus();
    settle();
    tick();
    settle();
    check("t3_err_addr", err_addr, 32'h30000000);
    check("t3_err_valid", W'(err_valid), 32'h1);

    // Timeout: slave 1 never acks.
    tick();
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h20400010;
    exp_q.push_back({1'b1, 32'h0});
    settle();
    check("t4_stall", W'(m_stall), '0);
    tick();
    m_stb = 1'b0;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      settle();
      if (m_err) first = i;
      tick();
    end
    check("t4_timeout_latency", W'(first - 1), 32'd8);
    s_ack = 2'b10; s_data_in[63:32] = 32'hBAD0BAD0;
    settle();
    check("t4_stray_ack", W'(m_ack), '0);
    tick();
    idle_bus();
    settle();
    check("t4_err_addr", err_addr, 32'h20400010);

    // Slave 0 junk while slave 1 is selected.
    tick();
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h20400020;
    settle();
    check("t5_s_stb", W'(s_stb), 32'h2);
    tick();
    m_stb = 1'b0;
    s_ack = 2'b01; s_data_in[31:0] = 32'hA5A5A5A5;
    settle();
    check("t5_no_unsel_ack", W'(m_ack), '0);
    check("t5_no_unsel_data", m_data_in, '0);
    tick();
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    s_ack = 2'b11; s_data_in[63:32] = 32'hCAFEF00D;
    settle();
    tick();
    s_ack = 2'b01;
    settle();
    check("t5_idle_no_ack", W'(m_ack), '0);
    tick();
    idle_bus();

    // Abort by dropping m_cyc, ack arriving in the abort cycle and after.
    tick();
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h10000008;
    settle();
    tick();
    m_stb = 1'b0; m_cyc = 1'b0;
    s_ack = 2'b01; s_data_in[31:0] = 32'h55555555;
    settle();
    check("t6_abort_no_ack", W'(m_ack), '0);
    tick();
    m_cyc = 1'b1;
    settle();
    check("t6_late_ack", W'(m_ack), '0);
    tick();
    idle_bus();

    // Reset asserted mid-transfer.
    tick();
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h10000000;
    settle();
    tick();
    m_stb = 1'b0;
    reset = 1'b0;
    settle();
    tick();
    reset = 1'b1;
    s_ack = 2'b01; s_data_in[31:0] = 32'h11111111;
    settle();
    check("t7_m_ack", W'(m_ack), '0);
    check("t7_m_err", W'(m_err), '0);
    check("t7_m_stall", W'(m_stall), '0);
    check("t7_s_stb", W'(s_stb), '0);
    check("t7_m_data_in", m_data_in, '0);
    check("t7_err_valid", W'(err_valid), '0);
    check("t7_err_addr", err_addr, '0);
    tick();
    idle_bus();
    repeat (3) tick();
    check("queue_drained", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
